mem_access: RTL
===============

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 valid_i  in  1  EX/MEM holds a valid instruction.
REQ-004 alu_result_i  in  32  ALU result; this is the memory byte address for loads and stores.
REQ-005 store_data_i  in  32  store data.
REQ-006 write_reg_addr_i  in  5  destination register.
REQ-007 control_i  in  8  control bus: bit2 write-back source (0 Mem, 1 Reg), bit3 write-back enable, bit4 mem read, bit5 mem write.
REQ-008 stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
REQ-009 result_o  out  32  write-back data to MEM_WB.
REQ-010 write_reg_addr_o  out  5  destination register to MEM_WB.
REQ-011 control_o  out  8  control bus to MEM_WB; all-zero value is a bubble.
REQ-012 err_o  out  1  one-cycle pulse on misaligned, illegal or timed-out access.
REQ-013 dmem_req_o  out  1  memory request.
REQ-014 dmem_we_o  out  1  1 = write, 0 = read.
REQ-015 dmem_addr_o  out  32  word-aligned address.
REQ-016 dmem_wdata_o  out  32  write data.
REQ-017 dmem_ack_i  in  1  memory completion; dmem_rdata_i is valid in the same cycle.
REQ-018 dmem_rdata_i  in  32  read data.
REQ-019 Parameter TIMEOUT, default 255, sets the maximum number of WAIT cycles before abort.

Function
REQ-020 A memory op is valid_i & (control_i[4] | control_i[5]).
- Any other valid_i=1 case is a non-memory op.
REQ-021 FSM states: IDLE, WAIT, DONE.
REQ-022 IDLE, non-memory op, or valid_i=0: combinational pass-through, no stall.
- result_o = alu_result_i; write_reg_addr_o = write_reg_addr_i.
- control_o = control_i if valid_i, else 8'h00.
REQ-023 IDLE, memory op with alu_result_i[1:0]=0 and not both bit4 and bit5 set:
- stall_o=1 and control_o=8'h00 combinationally.
- Latch address, store data, register address and control.
- Clear timeout counter; next state WAIT.
REQ-024 IDLE, memory op that is misaligned or has bit4 and bit5 both set:
- No request issued.
- Latch the op and set an error flag; next state DONE.
- stall_o=1 and control_o=8'h00 this cycle.
REQ-025 WAIT outputs:
- dmem_req_o=1 and held until ack; dmem_we_o = latched bit5.
- dmem_addr_o and dmem_wdata_o come from the latches and are stable for the whole request.
- stall_o=1; control_o=8'h00.
REQ-026 WAIT on dmem_ack_i=1: capture dmem_rdata_i; next state DONE.
REQ-027 WAIT without ack: increment the counter.
- When the counter reaches TIMEOUT: set the error flag, drop the request, next state DONE.
REQ-028 DONE (one cycle), stall_o=0:
- Success: control_o = latched control; write_reg_addr_o = latched address.
- Success: result_o = captured read data if latched bit2=0, else latched ALU result.
- Error: control_o=8'h00 and err_o=1.
- Next state IDLE.
REQ-029 Minimum memory-op latency is 3 cycles (IDLE, WAIT with same-cycle ack, DONE).
- Each extra ack-wait cycle adds one cycle.
REQ-030 dmem_req_o=0 in IDLE and DONE.
- dmem_ack_i in IDLE or DONE is ignored.
REQ-031 Inputs need not be held by upstream after the detection cycle; the latched copies are authoritative.
REQ-032 dmem_addr_o is 0 in IDLE and DONE; it is never driven with a misaligned address.

Reset
REQ-033 On rst=1 at a clock edge:
- State IDLE; counter, latches and error flag cleared.
- dmem_req_o=0 and err_o=0 from the next cycle.
REQ-034 Reset during WAIT aborts the access.
- An ack arriving after reset is ignored.
- No write-back occurs for the aborted op.

Verification
REQ-035 ALU op, control_i=8'h0D, alu_result_i=32'h12 -> same cycle result_o=32'h12, control_o=8'h0D, stall_o=0, dmem_req_o=0.
REQ-036 Load at addr 32'h100, ack 2 cycles after req with rdata 32'hDEADBEEF -> stall_o high 4 cycles; DONE gives result_o=32'hDEADBEEF, control_o = latched control.
REQ-037 Store at addr 32'h204, data 32'hCAFE0001, same-cycle ack -> one req cycle with dmem_we_o=1 and wdata 32'hCAFE0001; total 3 cycles.
REQ-038 Load at addr 32'h102 -> no dmem_req_o; err_o pulse in cycle 2; control_o=8'h00 throughout.
REQ-039 Load with no ack, TIMEOUT=4 -> req high exactly 4 cycles, then err_o pulse and bubble.
REQ-040 rst asserted in the second WAIT cycle, ack one cycle later -> dmem_req_o=0 after the edge, no err_o, no non-zero control_o.

Source files
------------

// File: rtl/mem_access.sv
// MEM pipeline stage: passes non-memory ops straight through, and runs loads/stores
// through a stalling IDLE -> WAIT -> DONE handshake with the data memory.
module mem_access #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] store_data_i,
   input  logic [4:0]  write_reg_addr_i,
   input  logic [7:0]  control_i,
   output logic        stall_o,
   output logic [31:0] result_o,
   output logic [4:0]  write_reg_addr_o,
   output logic [7:0]  control_o,
   output logic        err_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [4:0]    wra_q, wra_d;
   logic [7:0]    ctrl_q, ctrl_d;
   logic          err_q, err_d;

   logic mem_op, bad_op;

   assign mem_op = valid_i & (control_i[4] | control_i[5]);
   // Misaligned or simultaneous read+write never reaches the memory.
   assign bad_op = (|alu_result_i[1:0]) | (control_i[4] & control_i[5]);

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      rdata_d          = rdata_q;
      wra_d            = wra_q;
      ctrl_d           = ctrl_q;
      err_d            = err_q;
      stall_o          = 1'b0;
      result_o         = alu_result_i;
      write_reg_addr_o = write_reg_addr_i;
      control_o        = valid_i ? control_i : 8'h00;
      err_o            = 1'b0;
      dmem_req_o       = 1'b0;
      dmem_we_o        = 1'b0;
      dmem_addr_o      = 32'h0;
      dmem_wdata_o     = 32'h0;

      case (state_q)
         IDLE: begin
            if (mem_op) begin
               stall_o   = 1'b1;
               control_o = 8'h00;
               addr_d    = alu_result_i;
               wdata_d   = store_data_i;
               wra_d     = write_reg_addr_i;
               ctrl_d    = control_i;
               cnt_d     = '0;
               err_d     = bad_op;
               state_d   = bad_op ? DONE : WAIT;
            end
         end
         WAIT: begin
            stall_o      = 1'b1;
            control_o    = 8'h00;
            dmem_req_o   = 1'b1;
            dmem_we_o    = ctrl_q[5];
            dmem_addr_o  = {addr_q[31:2], 2'b00};
            dmem_wdata_o = wdata_q;
            if (dmem_ack_i) begin
               rdata_d = dmem_rdata_i;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CW'(TIMEOUT)) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            write_reg_addr_o = wra_q;
            result_o         = ctrl_q[2] ? addr_q : rdata_q;
            if (err_q) begin
               control_o = 8'h00;
               err_o     = 1'b1;
            end else begin
               control_o = ctrl_q;
            end
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         wra_q   <= 5'h0;
         ctrl_q  <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wra_q   <= wra_d;
         ctrl_q  <= ctrl_d;
         err_q   <= err_d;
      end
   end

endmodule
